poly_decompress_seq: RTL and testbench

- Sequencer that decompresses one full Kyber polynomial from a packed bit-stream of d-bit fields into 256 coefficients in Z_3329.
- Accepts 32-bit packed words over a valid/ready input, extracts d-bit fields across word boundaries, applies round(x*q/2^d), and streams 16-bit coefficients out over valid/ready.
- Sits between the accelerator's operand buffer and the coefficient store.
- Replaces per-coefficient software issue of the combinational decompress ops.

---
 rtl/poly_decompress_seq.sv | 200 ++++++++++++++++++++
 tb/tb_poly_decompress_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_decompress_seq.sv
// ---------------------------------------------------------------------------
// poly_decompress_seq
//
// Decompresses one Kyber polynomial (NCOEF coefficients in Z_Q) from a packed
// little-endian bit-stream of d-bit fields. Each field x is rescaled to
// round(x*Q / 2^d) and streamed out as a 16-bit coefficient.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i, d_i     start pulse and field width (1, 4, 5, 10 or 11), IDLE only
//   in_valid_i / in_ready_o / in_data_i     32-bit packed word input
//   out_valid_o / out_ready_i / out_data_o  coefficient output (upper 4 bits 0)
//   busy_o           high while a polynomial is in flight (RUN or DONE)
//   done_o           one-cycle pulse after the last coefficient is accepted
//   err_o            one-cycle pulse after a start with an illegal d
//
// Optional feature (macro ATHOS_DECOMP_IDX_EN):
//   adds out_idx_o [7:0], the index of the coefficient currently on out_data_o.
// ---------------------------------------------------------------------------
module poly_decompress_seq #(
  parameter int NCOEF = 256,
  parameter int Q     = 3329
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  d_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
`ifdef ATHOS_DECOMP_IDX_EN
  output logic [7:0]  out_idx_o,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [8:0] LAST_COEF = 9'(NCOEF - 1);

  state_e      state_q, state_d;
  logic [3:0]  d_q, d_d;
  logic [63:0] buf_q, buf_d;
  logic [6:0]  cnt_q, cnt_d;      // valid bits held in buf_q
  logic [6:0]  words_q, words_d;  // words accepted this run (max 88)
  logic [8:0]  coef_q, coef_d;    // output handshakes this run
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_data_q, out_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef ATHOS_DECOMP_IDX_EN
  logic [7:0]  idx_q, idx_d;
`endif

  logic        accept, extract, out_hs;
  logic [63:0] buf_sh;
  logic [6:0]  cnt_sh;
  logic [10:0] field;
  logic [31:0] prod;

  function automatic logic d_legal(input logic [3:0] d);
    return (d == 4'd1) || (d == 4'd4) || (d == 4'd5) || (d == 4'd10) || (d == 4'd11);
  endfunction

  // Input stalls while more than 32 bits are buffered, so an appended word
  // always fits in the 64-bit buffer.
  assign in_ready_o  = (state_q == RUN) && (cnt_q <= 7'd32) && (words_q < {d_q, 3'b000});
  assign out_valid_o = out_valid_q;
  assign out_data_o  = {4'b0000, out_data_q};
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef ATHOS_DECOMP_IDX_EN
  assign out_idx_o   = idx_q;
`endif

  assign accept  = in_valid_i && in_ready_o;
  assign out_hs  = out_valid_q && out_ready_i;
  assign extract = (state_q == RUN) && (cnt_q >= {3'b000, d_q}) && (!out_valid_q || out_ready_i);

  // Low d bits of the buffer, then round(x*Q/2^d) via add-half-and-shift.
  assign field = buf_q[10:0] & ~(11'h7FF << d_q);
  assign prod  = 32'(field) * 32'(Q) + (32'd1 << (d_q - 4'd1));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    buf_sh      = buf_q;
    cnt_sh      = cnt_q;
`ifdef ATHOS_DECOMP_IDX_EN
    idx_d       = idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (d_legal(d_i)) begin
            state_d = RUN;
            d_d     = d_i;
            buf_d   = '0;
            cnt_d   = '0;
            words_d = '0;
            coef_d  = '0;
`ifdef ATHOS_DECOMP_IDX_EN
            idx_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        // Consume a field first; a word accepted in the same cycle lands
        // directly above the post-shift count.
        if (extract) begin
          buf_sh = buf_q >> d_q;
          cnt_sh = cnt_q - 7'(d_q);
        end
        buf_d = buf_sh;
        cnt_d = cnt_sh;
        if (accept) begin
          buf_d   = buf_sh | (64'(in_data_i) << cnt_sh);
          cnt_d   = cnt_sh + 7'd32;
          words_d = words_q + 7'd1;
        end

        if (out_hs) begin
          coef_d      = coef_q + 9'd1;
          out_valid_d = 1'b0;
        end
        if (extract) begin
          out_valid_d = 1'b1;
          out_data_d  = 12'(prod >> d_q);
`ifdef ATHOS_DECOMP_IDX_EN
          idx_d       = out_hs ? 8'(coef_q + 9'd1) : 8'(coef_q);
`endif
        end
        if (out_hs && (coef_q == LAST_COEF)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      d_q         <= '0;
      // NOTE: the bit buffer is a plain register, not a RAM, so it is reset like the rest.
      buf_q       <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ATHOS_DECOMP_IDX_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef ATHOS_DECOMP_IDX_EN
      idx_q       <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_poly_decompress_seq.sv
// ---------------------------------------------------------------------------
// tb_poly_decompress_seq
//
// Directed bench for poly_decompress_seq: legal widths with all-ones and
// single-bit streams, a ramp stream under random backpressure and input gaps,
// illegal start, start during a run, and reset in the middle of a polynomial.
// ---------------------------------------------------------------------------
module tb_poly_decompress_seq;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [3:0]  d_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
`ifdef ATHOS_DECOMP_IDX_EN
  logic [7:0]  out_idx_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  poly_decompress_seq dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .d_i        (d_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
`ifdef ATHOS_DECOMP_IDX_EN
    .out_idx_o  (out_idx_o),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream content: 0 = all ones, 1 = only field 0 is 1, 2 = ramp x = i mod 2^d.
  function automatic int field_val(input int mode, input int d, input int i);
    case (mode)
      0:       return (1 << d) - 1;
      1:       return (i == 0) ? 1 : 0;
      default: return i % (1 << d);
    endcase
  endfunction

  function automatic int exp_coef(input int mode, input int d, input int i);
    return (field_val(mode, d, i) * 3329 + (1 << (d - 1))) >> d;
  endfunction

  function automatic logic [31:0] make_word(input int mode, input int d, input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 32; j++) begin
      int b;
      b = 32 * k + j;
      w[j] = 1'((field_val(mode, d, b / d) >> (b % d)) & 1);
    end
    return w;
  endfunction

  // One polynomial. Inputs change on the falling edge; outputs are sampled
  // 1 ns later, which is when the next rising edge's handshakes are decided.
  task automatic run_poly(input int d, input int mode, input int first_exp,
                          input bit bp, input bit midstart, input int abort_at);
    int nwords, k, ncoef, cyc, done_cnt, err_cnt, first_cyc, last_cyc, extra;
    bit hold_in, stalled;
    logic [15:0] held;
    nwords = 8 * d; k = 0; ncoef = 0; cyc = 0; done_cnt = 0; err_cnt = 0;
    first_cyc = -1; last_cyc = 0; extra = 0; hold_in = 0; stalled = 0; held = '0;

    @(negedge clk_i); start_i = 1'b1; d_i = 4'(d);
    @(negedge clk_i); start_i = 1'b0;
    #1 check($sformatf("busy_on_d%0d", d), busy_o, 1);

    while (cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
      if (midstart) begin
        start_i = (cyc == 50);
        d_i     = (cyc == 50) ? 4'd4 : 4'(d);
      end
      if (!hold_in) begin
        // Past the last word keep offering data: in_ready_o must stay low.
        in_valid_i = (k < nwords && bp) ? ($urandom_range(3) != 0) : 1'b1;
        in_data_i  = (k < nwords) ? make_word(mode, d, k) : 32'hFFFF_FFFF;
      end
      out_ready_i = bp ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (stalled) check("hold", {15'd0, out_valid_o, out_data_o}, {15'd0, 1'b1, held});
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (in_valid_i && in_ready_o) begin
        k++;
        hold_in = 1'b0;
      end else begin
        hold_in = in_valid_i;
      end
      if (out_valid_o && out_ready_i) begin
        if (ncoef == 0) check($sformatf("first_d%0d", d), out_data_o, first_exp);
        check($sformatf("coef_d%0d_%0d", d, ncoef), out_data_o, exp_coef(mode, d, ncoef));
`ifdef ATHOS_DECOMP_IDX_EN
        check("idx", out_idx_o, ncoef % 256);
`endif
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        ncoef++;
      end
      stalled = out_valid_o && !out_ready_i;
      held    = out_data_o;
      if (abort_at != 0 && ncoef == abort_at) break;
      if (ncoef >= 256) begin
        extra++;
        if (extra > 4) break;
      end
    end

    if (abort_at != 0) begin
      check("abort_reached", ncoef, abort_at);
      rst_ni = 1'b0;
      #1;
      check("rst_outs", {26'd0, in_ready_o, out_valid_o, busy_o, done_o, err_o, |out_data_o}, 0);
      in_valid_i = 1'b0; out_ready_i = 1'b0; start_i = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      return;
    end

    check($sformatf("ncoef_d%0d", d), ncoef, 256);
    check($sformatf("words_d%0d", d), k, nwords);
    check($sformatf("done_cnt_d%0d", d), done_cnt, 1);
    check($sformatf("busy_off_d%0d", d), busy_o, 0);
    check($sformatf("err_cnt_d%0d", d), err_cnt, 0);
    if (!bp) check($sformatf("thruput_d%0d", d), last_cyc - first_cyc, 255);
    in_valid_i = 1'b0;
    start_i    = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; d_i = '0; in_valid_i = 1'b0;
    in_data_i = '0; out_ready_i = 1'b0;
    #1;
    check("reset_outs", {26'd0, in_ready_o, out_valid_o, busy_o, done_o, err_o, |out_data_o}, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Illegal width: err_o pulses once, nothing starts.
    @(negedge clk_i); start_i = 1'b1; d_i = 4'd3;
    @(negedge clk_i); start_i = 1'b0;
    #1;
    check("err_pulse", err_o, 1);
    check("ill_busy", busy_o, 0);
    check("ill_ready", in_ready_o, 0);
    @(negedge clk_i); #1;
    check("err_clear", err_o, 0);
    check("ill_busy2", busy_o, 0);

    // Hand-computed first coefficients: 1665, 3121, 3225, 3326, 3327.
    run_poly(1,  1, 1665, 1'b0, 1'b0, 0);
    run_poly(4,  0, 3121, 1'b0, 1'b0, 0);
    run_poly(5,  0, 3225, 1'b0, 1'b0, 0);
    run_poly(10, 0, 3326, 1'b0, 1'b0, 0);
    run_poly(11, 0, 3327, 1'b0, 1'b0, 0);

    // Ramp under backpressure and input gaps, with a stray start mid-run.
    run_poly(10, 2, 0, 1'b1, 1'b1, 0);

    // Reset after 100 coefficients, then a clean d=1 polynomial.
    run_poly(4, 0, 3121, 1'b0, 1'b0, 100);
    run_poly(1, 1, 1665, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
